// File: rtl/hsv_core_commit.sv
// Commit stage: retires execution-unit packets into the register file, counts retired
// instructions, and sequences flush/acknowledge/redirect on committed control-flow changes.
module hsv_core_commit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned RETIRE_W  = 64
) (
    input  logic                 clk_core,
    input  logic                 rst_core,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_result,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [4:0]           in_rd,
    input  logic                 in_writeback,
    input  logic                 in_jump,
    input  logic [XLEN-1:0]      in_jump_target,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 flush_req,
    input  logic [NUM_UNITS-1:0] flush_ack,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic [RETIRE_W-1:0]  retired_count
);

    typedef enum logic [1:0] {StRun, StFlush, StRedirect} state_e;

    state_e               state;
    logic [XLEN-1:0]      jump_target;
    logic [NUM_UNITS-1:0] ack_mask;
    logic [NUM_UNITS-1:0] ack_seen;

    // The pc travels with the packet for tracing only; nothing here consumes it.
    logic unused_pc;
    assign unused_pc = ^in_pc;

    assign in_ready = (state != StRedirect);
    assign ack_seen = ack_mask | flush_ack;

    always_ff @(posedge clk_core or negedge rst_core) begin
        if (!rst_core) begin
            state          <= StRun;
            jump_target    <= '0;
            ack_mask       <= '0;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            flush_req      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            retired_count  <= '0;
        end else begin
            rf_we          <= 1'b0;
            redirect_valid <= 1'b0;
            unique case (state)
                StRun: begin
                    if (in_valid) begin
                        retired_count <= retired_count + 1'b1;
                        if (in_writeback && (in_rd != 5'd0)) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= in_rd;
                            rf_wdata <= in_result;
                        end
                        if (in_jump) begin
                            jump_target <= in_jump_target;
                            ack_mask    <= '0;
                            flush_req   <= 1'b1;
                            state       <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    // Packets accepted here are wrong-path and simply dropped.
                    if (&ack_seen) begin
                        ack_mask       <= '0;
                        flush_req      <= 1'b0;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= jump_target;
                        state          <= StRedirect;
                    end else begin
                        ack_mask <= ack_seen;
                    end
                end
                StRedirect: begin
                    state <= StRun;
                end
                default: begin
                    state <= StRun;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hsv_core_commit.sv
// Self-checking bench for hsv_core_commit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_hsv_core_commit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NU   = 4;
    localparam int unsigned RW   = 64;

    logic            clk_core = 1'b0;
    logic            rst_core = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_result = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic [4:0]      in_rd = '0;
    logic            in_writeback = 1'b0;
    logic            in_jump = 1'b0;
    logic [XLEN-1:0] in_jump_target = '0;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            flush_req;
    logic [NU-1:0]   flush_ack = '0;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [RW-1:0]   retired_count;

    hsv_core_commit #(.XLEN(XLEN), .NUM_UNITS(NU), .RETIRE_W(RW)) dut (
        .clk_core      (clk_core),
        .rst_core      (rst_core),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_pc         (in_pc),
        .in_rd         (in_rd),
        .in_writeback  (in_writeback),
        .in_jump       (in_jump),
        .in_jump_target(in_jump_target),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .flush_req     (flush_req),
        .flush_ack     (flush_ack),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .retired_count (retired_count)
    );

    always #5 clk_core = ~clk_core;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: mode 0 = running, 1 = flushing, 2 = redirecting.
    int              m_mode;
    logic [RW-1:0]   m_count;
    logic [XLEN-1:0] m_target;
    bit              m_seen [NU];
    logic            e_we;
    logic [4:0]      e_waddr;
    logic [XLEN-1:0] e_wdata;
    logic            e_flush;
    logic            e_rvalid;
    logic [XLEN-1:0] e_rpc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_count  = '0;
        m_target = '0;
        for (int i = 0; i < NU; i++) m_seen[i] = 1'b0;
        e_we     = 1'b0;
        e_waddr  = '0;
        e_wdata  = '0;
        e_flush  = 1'b0;
        e_rvalid = 1'b0;
        e_rpc    = '0;
    endtask

    // Advance the model over the coming rising edge using the currently driven inputs.
    task automatic model_step();
        bool_all_seen: begin
        end
        e_we     = 1'b0;
        e_rvalid = 1'b0;
        case (m_mode)
            0: if (in_valid) begin
                m_count = m_count + 1;
                if (in_writeback && in_rd != 0) begin
                    e_we    = 1'b1;
                    e_waddr = in_rd;
                    e_wdata = in_result;
                end
                if (in_jump) begin
                    m_target = in_jump_target;
                    for (int i = 0; i < NU; i++) m_seen[i] = 1'b0;
                    e_flush = 1'b1;
                    m_mode  = 1;
                end
            end
            1: begin
                int nseen = 0;
                for (int i = 0; i < NU; i++) begin
                    if (flush_ack[i]) m_seen[i] = 1'b1;
                    if (m_seen[i]) nseen++;
                end
                if (nseen == NU) begin
                    e_flush  = 1'b0;
                    e_rvalid = 1'b1;
                    e_rpc    = m_target;
                    m_mode   = 2;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    // One clock: update model, let the edge happen, compare on the falling edge.
    task automatic cycle();
        model_step();
        @(posedge clk_core);
        @(negedge clk_core);
        chk("rf_we", rf_we, e_we);
        if (e_we) begin
            chk("rf_waddr", rf_waddr, e_waddr);
            chk("rf_wdata", rf_wdata, e_wdata);
        end
        chk("flush_req", flush_req, e_flush);
        chk("redirect_valid", redirect_valid, e_rvalid);
        chk("redirect_pc", redirect_pc, e_rpc);
        chk("retired_count", retired_count, m_count);
        chk("in_ready", in_ready, m_mode != 2);
    endtask

    task automatic pkt(input logic v, input logic [4:0] rd, input logic [31:0] res,
                       input logic wb, input logic j, input logic [31:0] tgt);
        in_valid       = v;
        in_rd          = rd;
        in_result      = res;
        in_writeback   = wb;
        in_jump        = j;
        in_jump_target = tgt;
        in_pc          = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".rf_we"}, rf_we, 0);
        chk({tag, ".rf_waddr"}, rf_waddr, 0);
        chk({tag, ".rf_wdata"}, rf_wdata, 0);
        chk({tag, ".flush_req"}, flush_req, 0);
        chk({tag, ".redirect_valid"}, redirect_valid, 0);
        chk({tag, ".redirect_pc"}, redirect_pc, 0);
        chk({tag, ".retired_count"}, retired_count, 0);
    endtask

    initial begin
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk_core);
        rst_core = 1'b1;
        chk("reset.in_ready", in_ready, 1);

        // Basic write.
        pkt(1, 5'd5, 32'h1234, 1, 0, 0);
        cycle();
        chk("lit.we1", rf_we, 1);
        chk("lit.waddr1", rf_waddr, 5);
        chk("lit.wdata1", rf_wdata, 32'h1234);
        chk("lit.count1", retired_count, 1);

        // x0 write suppressed but still retired.
        pkt(1, 5'd0, 32'hFFFF_FFFF, 1, 0, 0);
        cycle();
        chk("lit.x0_we", rf_we, 0);
        chk("lit.x0_count", retired_count, 2);

        // Back-to-back writes.
        for (int i = 1; i <= 4; i++) begin
            pkt(1, 5'(i), 32'hA000 + 32'(i), 1, 0, 0);
            chk("lit.b2b_ready", in_ready, 1);
            cycle();
            chk("lit.b2b_we", rf_we, 1);
            chk("lit.b2b_waddr", rf_waddr, 64'(i));
        end
        chk("lit.b2b_count", retired_count, 6);

        // Jump with link write, staggered acks, wrong-path packets.
        pkt(1, 5'd1, 32'h104, 1, 1, 32'h200);
        cycle();
        chk("lit.jump_we", rf_we, 1);
        chk("lit.jump_wdata", rf_wdata, 32'h104);
        chk("lit.jump_flush", flush_req, 1);
        pkt(1, 5'd7, 32'hDEAD, 1, 0, 0);
        cycle();
        flush_ack = 4'b1011;
        pkt(1, 5'd8, 32'hBEEF, 1, 1, 32'h999);
        cycle();
        chk("lit.flush_wp_we", rf_we, 0);
        chk("lit.flush_partial", flush_req, 1);
        flush_ack = 4'b0000;
        pkt(0, 0, 0, 0, 0, 0);
        cycle();
        chk("lit.flush_sticky", flush_req, 1);
        flush_ack = 4'b0100;
        cycle();
        chk("lit.redir_valid", redirect_valid, 1);
        chk("lit.redir_pc", redirect_pc, 32'h200);
        chk("lit.redir_ready", in_ready, 0);
        chk("lit.redir_flush", flush_req, 0);
        chk("lit.flush_count", retired_count, 7);
        flush_ack = '0;
        cycle();
        chk("lit.post_valid", redirect_valid, 0);
        chk("lit.post_ready", in_ready, 1);
        chk("lit.post_pc", redirect_pc, 32'h200);

        // Reset while flushing.
        pkt(1, 5'd2, 32'h55, 1, 1, 32'h300);
        cycle();
        pkt(0, 0, 0, 0, 0, 0);
        cycle();
        rst_core = 1'b0;
        #1;
        check_all_zero("midflush");
        model_reset();
        @(negedge clk_core);
        rst_core  = 1'b1;
        flush_ack = '1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("lit.no_redirect", redirect_valid, 0);
        end

        // Second jump right after a redirect with stale acks still high.
        pkt(1, 5'd3, 32'h77, 1, 1, 32'h400);
        flush_ack = '0;
        cycle();
        pkt(0, 0, 0, 0, 0, 0);
        flush_ack = '1;
        cycle();
        chk("lit.redir2", redirect_pc, 32'h400);
        cycle();
        pkt(1, 5'd4, 32'h88, 1, 1, 32'h500);
        cycle();
        chk("lit.stale_flush", flush_req, 1);
        pkt(0, 0, 0, 0, 0, 0);
        flush_ack = '0;
        cycle();
        chk("lit.stale_ignored", flush_req, 1);
        chk("lit.stale_noredir", redirect_valid, 0);
        flush_ack = '1;
        cycle();
        chk("lit.redir3_valid", redirect_valid, 1);
        chk("lit.redir3_pc", redirect_pc, 32'h500);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            pkt(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), $urandom);
            for (int u = 0; u < NU; u++) flush_ack[u] = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
